// File: rtl/offset_arbiter_if.sv
// Bus between the requesting control units, the shared offset adder and the arbiter.
interface offset_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);
  logic                     hold;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       addr1_sel;
  logic [2*NUM_REQ-1:0]     addr2_sel;
  logic [16*NUM_REQ-1:0]    ir_bus;
  logic [16*NUM_REQ-1:0]    pc_bus;
  logic [16*NUM_REQ-1:0]    sr1_bus;
  logic                     ADDR1MUX;
  logic [1:0]               ADDR2MUX;
  logic [15:0]              IR;
  logic [15:0]              PC;
  logic [15:0]              SR1_OUT;
  logic [15:0]              offset;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [15:0]              result;
  logic [IDW-1:0]           result_id;
  logic                     busy;

  // Requester/adder side.
  modport master (
    output hold, req, addr1_sel, addr2_sel, ir_bus, pc_bus, sr1_bus, offset,
    input  ADDR1MUX, ADDR2MUX, IR, PC, SR1_OUT, grant, done, result, result_id, busy
  );

  // Arbiter side.
  modport slave (
    input  hold, req, addr1_sel, addr2_sel, ir_bus, pc_bus, sr1_bus, offset,
    output ADDR1MUX, ADDR2MUX, IR, PC, SR1_OUT, grant, done, result, result_id, busy
  );
endinterface

// File: rtl/offset_arbiter.sv
// Round-robin arbiter sharing one offset adder between NUM_REQ requesters.
// The winner's operands are routed to the adder in the grant cycle; the sum is
// registered and returned with a one-cycle done pulse in the following cycle.
module offset_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input logic              Clk,
  input logic              Reset,
  offset_arbiter_if.slave  bus
);

  logic [IDW-1:0]     ptr_q;
  logic [NUM_REQ-1:0] mask_q;
  logic [NUM_REQ-1:0] done_q;
  logic [15:0]        result_q;
  logic [IDW-1:0]     result_id_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     win;
  logic               found;
  logic [IDW-1:0]     ptr_next;

  // Round-robin scan starting at ptr; grants are suppressed during reset and hold.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    elig  = bus.req & ~mask_q;
    found = 1'b0;
    win   = '0;
    grant = '0;
    if (!Reset && !bus.hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = (32'(ptr_q) + i) % NUM_REQ;
        if (!found && elig[IDW'(idx)]) begin
          found = 1'b1;
          win   = IDW'(idx);
        end
      end
    end
    if (found) grant[win] = 1'b1;
  end

  assign ptr_next = IDW'((32'(win) + 1) % NUM_REQ);

  // Route the winner's operand slices to the shared adder; all zero when idle.
  always_comb begin
    bus.ADDR1MUX = 1'b0;
    bus.ADDR2MUX = 2'b00;
    bus.IR       = '0;
    bus.PC       = '0;
    bus.SR1_OUT  = '0;
    if (found) begin
      bus.ADDR1MUX = bus.addr1_sel[win];
      bus.ADDR2MUX = bus.addr2_sel[win*2 +: 2];
      bus.IR       = bus.ir_bus[win*16 +: 16];
      bus.PC       = bus.pc_bus[win*16 +: 16];
      bus.SR1_OUT  = bus.sr1_bus[win*16 +: 16];
    end
  end

  // Pointer, mask and result registers; mask blocks a winner for one cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q       <= '0;
      mask_q      <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      mask_q <= grant;
      done_q <= grant;
      busy_q <= found;
      if (found) begin
        ptr_q       <= ptr_next;
        result_q    <= bus.offset;
        result_id_q <= win;
      end
    end
  end

  assign bus.grant     = grant;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/offset_arbiter.md
Name: offset_arbiter

Overview:
- Shares one address/offset adder (ADDR1MUX/ADDR2MUX select, IR/PC/SR1 operands, 16-bit sum) between NUM_REQ shader-core requesters.
- Grants one request per cycle using round-robin priority and routes the winner's operands to the shared adder.
- Registers the adder result and returns it with a one-cycle done pulse to the winning requester.
- Sits between the per-core control units and the single shared offset adder in the GPU datapath.

Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- IDW, $clog2(NUM_REQ): width of the requester index.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- hold  in  1  shared adder is unavailable this cycle; no grant is issued.
- req  in  NUM_REQ  per-requester request level.
- addr1_sel  in  NUM_REQ  per-requester ADDR1MUX select (0 = PC, 1 = SR1).
- addr2_sel  in  2*NUM_REQ  per-requester ADDR2MUX select; requester i uses bits [2i+1:2i].
- ir_bus  in  16*NUM_REQ  per-requester IR; requester i uses bits [16i+15:16i].
- pc_bus  in  16*NUM_REQ  per-requester PC.
- sr1_bus  in  16*NUM_REQ  per-requester SR1 value.
- ADDR1MUX  out  1  select driven to the shared adder.
- ADDR2MUX  out  2  select driven to the shared adder.
- IR  out  16  operand driven to the shared adder.
- PC  out  16  operand driven to the shared adder.
- SR1_OUT  out  16  operand driven to the shared adder.
- offset  in  16  combinational sum returned by the shared adder.
- grant  out  NUM_REQ  one-hot combinational grant for the current cycle.
- done  out  NUM_REQ  registered one-hot pulse; result is valid for requester i.
- result  out  16  registered adder result.
- result_id  out  IDW  index of the requester that owns result.
- busy  out  1  registered; high if any grant occurred in the previous cycle.

Behaviour:
- Reset values: ptr = 0, mask = 0, done = 0, result = 0, result_id = 0, busy = 0.
- During reset, grant = 0 and the adder outputs are all 0.
- Eligible set is elig = req & ~mask.
- Arbitration (combinational):
  - If hold = 1 or elig = 0, then grant = 0.
  - Otherwise grant the first eligible index found scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
- Adder drive:
  - When grant[k] = 1, ADDR1MUX/ADDR2MUX/IR/PC/SR1_OUT carry requester k's slices.
  - When grant = 0, all adder outputs are driven to 0, so ADDR2MUX = 00 and the adder sees PC + 0 = 0.
- Latency: a request granted in cycle T produces done[k] = 1, result = offset sampled in T, and result_id = k in cycle T+1.
- done lasts exactly one cycle, and at most one done bit is ever set.
- result and result_id hold their last values while done = 0.
- Pointer update on a grant to k: ptr ← (k+1) mod NUM_REQ. The pointer is unchanged when there is no grant, including when hold = 1.
- Mask update: mask ← grant every cycle, so a requester granted in T is ineligible in T+1.
  - This gives the requester time to update operands or drop req after seeing done.
  - Per-requester throughput is therefore at most 1 per 2 cycles; aggregate throughput is 1 per cycle.
- Requester contract:
  - Hold req and operands stable until done.
  - A req still high in the cycle after done (T+2 onward) is treated as a new request.
- hold while requests are pending: no grant, no done in the next cycle, ptr unchanged, and mask cleared (mask ← 0).
- Pending requests are never dropped; each waits at most NUM_REQ-1 grants after becoming eligible (starvation-free).
- Operand changes on non-granted requesters have no effect.
- Asynchronous Reset asserted mid-operation: an in-flight result is discarded, done is forced to 0 immediately, and ptr returns to 0.
- Arithmetic: result is the 16-bit adder sum; wrap-around is modulo 2^16 and no carry is reported.

Test Plan:
- Single request: req = 0001 with addr1_sel = 0, addr2_sel = 10, PC = 0x3000, IR[8:0] = 0x1FF (−1), and the adder model connected. Required: grant = 0001 in T; done = 0001, result = 0x2FFF, result_id = 0 in T+1.
- All four requesting continuously from reset. Required: grant order 0,1,2,3,0,…; one done per cycle; every requester served once in each 4-cycle window.
- Back-to-back request from the same requester: req = 0001 held high. Required: grants only in alternate cycles (mask), with done in the cycles between grants.
- Pointer wrap: last grant went to 3 and req = 1001. Required: requester 0 is granted next, then requester 3.
- hold: hold = 1 for 3 cycles with req = 0110. Required: no grant and no done during hold; ptr unchanged; the first grant after hold deasserts follows the saved ptr.
- Reset mid-operation: assert Reset in T+1 after a grant in T. Required: done = 0, result = 0, busy = 0 immediately; after release, requester 0 has top priority.
